ram_access_ctrl: RTL
====================

Name: ram_access_ctrl

Overview:
- Request/response front-end that sits directly upstream of the 16-bit word RAM array and drives its read, write, address and data pins.
- Accepts one read or write transaction at a time over a valid/ready handshake.
- Sequences the RAM control pins for a fixed number of cycles and returns the read data or a write acknowledgement over a second valid/ready handshake.
- Guarantees the RAM never sees read and write asserted together, and that address and data stay stable for the whole access.

Parameters:
- DATA_W, 16, RAM word width.
- ADDR_W, 6, RAM address width.
- WR_CYC, 1, cycles mem_w is held high per write (1..15).
- RD_LAT, 2, cycles mem_r is held high before mem_o is sampled (1..15).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  target word address.
- req_data  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  DATA_W  read data; 0 for write acknowledgements.
- rsp_err  out  1  write-verify mismatch flag (see Optional Feature).
- mem_r  out  1  RAM read enable.
- mem_w  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_d  out  DATA_W  RAM write data.
- mem_o  in  DATA_W  RAM read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: one clock only, reset is synchronous and active-low. Any rising clk edge with rst_n=0 sets state to IDLE, clears the cycle counter, and drives every registered output to 0: req_ready, rsp_valid, rsp_data, rsp_err, mem_r, mem_w, mem_addr, mem_d, busy.
- First cycle after reset release: req_ready=1.
- All outputs are registered.
- States: IDLE, WR, RD, VRD (feature only), RSP.
- IDLE:
  - req_ready=1, mem_r=0, mem_w=0; mem_addr and mem_d hold their last values.
  - Accept on a rising edge with req_valid & req_ready: latch req_addr into mem_addr and req_data into mem_d, clear req_ready, set busy.
  - Next state is WR if req_we=1, otherwise RD.
- WR:
  - mem_w=1 for exactly WR_CYC consecutive cycles, starting the cycle after acceptance.
  - Then mem_w=0 and next state is RSP with rsp_data=0 (or VRD when the feature is on).
- RD:
  - mem_r=1 for exactly RD_LAT cycles.
  - On the edge ending the last mem_r cycle, capture mem_o into rsp_data; mem_r=0; next state RSP.
- RSP:
  - rsp_valid=1, held with rsp_data and rsp_err stable until rsp_ready=1 at a rising edge.
  - On that edge: rsp_valid=0, req_ready=1, busy=0, state IDLE.
  - If rsp_ready is already high on the first RSP cycle, the handshake completes on that edge.
- No overlap between transactions: req_ready stays low from acceptance until the response handshake.
  - Minimum period is 1 + WR_CYC + 1 cycles for writes and 1 + RD_LAT + 1 cycles for reads.
- Invariants:
  - mem_r & mem_w is never 1.
  - mem_addr and mem_d never change while mem_r or mem_w is high.
- The counter counts down from WR_CYC-1 or RD_LAT-1; the state ends when it reaches 0. There is no wrap-around.
- Reset mid-operation: the access is aborted at the reset edge and mem_w drops to 0 that edge. The RAM word may hold partial or new data. No response is generated.
- req_valid while busy: ignored, with no latching.
- Address/data width: pass straight through, with no arithmetic.

Optional Feature:
- Macro: RAM_ACCESS_CTRL_VERIFY_EN.
- Defined:
  - After WR the controller enters VRD: mem_r=1 for RD_LAT cycles at the same mem_addr, then samples mem_o.
  - rsp_err=1 if mem_o != mem_d, else 0; rsp_data=0 for the acknowledgement.
  - Write period grows by RD_LAT cycles.
  - rsp_err is 0 for read responses.
- Undefined: there is no VRD state, and rsp_err is constant 0.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req_valid=1 -> all outputs 0; req_ready=1 on the first cycle after release.
- Write then read, defaults: write addr 31, data 256 -> mem_w=1 for 1 cycle with mem_addr=31, mem_d=256; ack with rsp_data=0. Then read addr 31 with a RAM model returning 256 -> mem_r high for 2 cycles; rsp_data=256.
- Backpressure: read addr 21 (model value 64) with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data=64 held stable; req_ready=0 throughout; IDLE one edge after rsp_ready=1.
- Back-to-back: req_valid held high for writes to addr 1, 2, 3 with rsp_ready=1 -> accepted 3 cycles apart; mem_r and mem_w never both high.
- Reset mid-read: rst_n=0 during the second RD cycle -> mem_r=0 and rsp_valid=0 after that edge; no response ever issued.
- Verify (RAM_ACCESS_CTRL_VERIFY_EN): write 0x00FF to addr 5 with the model returning 0x00FE -> ack with rsp_err=1; with a correct model rsp_err=0, and write latency is 1+1+2+1 cycles.

Source files
------------

// File: rtl/ram_access_ctrl.sv
// Valid/ready front-end for a single-port word RAM: sequences mem_r/mem_w for a fixed
// cycle count per access. Define RAM_ACCESS_CTRL_VERIFY_EN to add write read-back verification.
module ram_access_ctrl #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned WR_CYC = 1,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              mem_r,
    output logic              mem_w,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_d,
    input  logic [DATA_W-1:0] mem_o,
    output logic              busy
);

`ifdef RAM_ACCESS_CTRL_VERIFY_EN
    typedef enum logic [2:0] {IDLE, WR, RD, VRD, RSP} state_t;
`else
    typedef enum logic [2:0] {IDLE, WR, RD, RSP} state_t;
`endif

    localparam logic [3:0] WR_LOAD = 4'(WR_CYC - 1);
    localparam logic [3:0] RD_LOAD = 4'(RD_LAT - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                mem_r_q, mem_r_d;
    logic                mem_w_q, mem_w_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_d_q, mem_d_d;
    logic                busy_q, busy_d;
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
    logic                rsp_err_q, rsp_err_d;
`endif

    logic accept;
    assign accept = (state_q == IDLE) && req_valid && req_ready_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            mem_r_q     <= 1'b0;
            mem_w_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_d_q     <= '0;
            busy_q      <= 1'b0;
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            mem_r_q     <= mem_r_d;
            mem_w_q     <= mem_w_d;
            mem_addr_q  <= mem_addr_d;
            mem_d_q     <= mem_d_d;
            busy_q      <= busy_d;
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = req_we ? WR : RD;
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
            WR:   if (cnt_q == '0) state_d = VRD;
            VRD:  if (cnt_q == '0) state_d = RSP;
`else
            WR:   if (cnt_q == '0) state_d = RSP;
`endif
            RD:   if (cnt_q == '0) state_d = RSP;
            RSP:  if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead so every pin comes straight from a flop.
    always_comb begin
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        mem_r_d     = 1'b0;
        mem_w_d     = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_d_d     = mem_d_q;
        busy_d      = busy_q;
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
                if (accept) begin
                    mem_addr_d  = req_addr;
                    mem_d_d     = req_data;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    if (req_we) begin
                        mem_w_d = 1'b1;
                        cnt_d   = WR_LOAD;
                    end else begin
                        mem_r_d = 1'b1;
                        cnt_d   = RD_LOAD;
                    end
                end
            end
            WR: begin
                if (cnt_q == '0) begin
                    rsp_data_d = '0;
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
                    mem_r_d    = 1'b1;
                    cnt_d      = RD_LOAD;
`else
                    rsp_valid_d = 1'b1;
`endif
                end else begin
                    mem_w_d = 1'b1;
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            RD: begin
                if (cnt_q == '0) begin
                    rsp_data_d  = mem_o;
                    rsp_valid_d = 1'b1;
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
                    rsp_err_d   = 1'b0;
`endif
                end else begin
                    mem_r_d = 1'b1;
                    cnt_d   = cnt_q - 4'd1;
                end
            end
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
            VRD: begin
                if (cnt_q == '0) begin
                    rsp_err_d   = (mem_o != mem_d_q);
                    rsp_data_d  = '0;
                    rsp_valid_d = 1'b1;
                end else begin
                    mem_r_d = 1'b1;
                    cnt_d   = cnt_q - 4'd1;
                end
            end
`endif
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                req_ready_d = 1'b0;
            end
        endcase
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign mem_r     = mem_r_q;
    assign mem_w     = mem_w_q;
    assign mem_addr  = mem_addr_q;
    assign mem_d     = mem_d_q;
    assign busy      = busy_q;
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule
